sipo_nbit_rx: RTL and testbench

- Serial-in, parallel-out receiver: the receiving end of the team's N-bit parallel-to-serial link.
- Samples one serial bit per enabled clock and assembles N-bit words.
- Presents each completed word on a registered parallel output with a valid/ready handshake.
- Flags overrun when a word completes before the previous one is accepted.

---
 rtl/sipo_pkg.sv | 24 ++
 rtl/sipo_shift_reg.sv | 38 +++
 rtl/sipo_nbit_rx.sv | 146 ++++++++++++++
 tb/tb_sipo_nbit_rx.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the serial-in parallel-out receiver.
// Frame length depends on SIPO_PARITY_CHECK_EN (adds one even-parity bit per frame).
package sipo_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

`ifdef SIPO_PARITY_CHECK_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic int frame_len(input int n);
      return PARITY_EN ? n + 1 : n;
   endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// N-bit serial shift register with direction select, enable and synchronous clear.
// nxt_o is the next-state value, so a word can be captured on the edge its last bit arrives.
module sipo_shift_reg
   import sipo_pkg::*;
#(
   parameter int N         = 4,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   input  logic         clr_i,
   input  logic         d_i,
   output logic [N-1:0] nxt_o
);

   logic [N-1:0] sr_q, sr_d, base;

   // A clear combined with an enable loads the new bit into an otherwise empty register.
   always_comb begin
      base = clr_i ? '0 : sr_q;
      sr_d = base;
      if (en_i) begin
         sr_d = MSB_FIRST ? {base[N-2:0], d_i} : {d_i, base[N-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign nxt_o = sr_d;

endmodule

// File: rtl/sipo_nbit_rx.sv
// Serial-in parallel-out receiver with valid/ready output and sticky overrun flag.
// Define SIPO_PARITY_CHECK_EN for N+1 bit frames with even-parity checking on par_err_out.
module sipo_nbit_rx
   import sipo_pkg::*;
#(
   parameter int N         = 4,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic         clk,
   input  logic         reset_al_in,
   input  logic         en_in,
   input  logic         d_in,
   input  logic         sync_in,
   input  logic         ready_in,
   input  logic         clr_in,
   output logic [N-1:0] q_out,
   output logic         valid_out,
   output logic         overrun_out,
   output logic         par_err_out
);

   localparam int FRAME = frame_len(N);
   localparam int CW    = cnt_w(N);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  word;
   logic          last_bit, done, shift_en;
   logic [N-1:0]  q_q;
   logic          valid_q, ovr_q;
   state_e        state_q;

   assign last_bit = (cnt_q == CW'(FRAME - 1));
   assign done     = en_in & ~sync_in & last_bit;
   // The parity bit slot never enters the data register.
   assign shift_en = en_in & (sync_in | (cnt_q < CW'(N)));

   sipo_shift_reg #(
      .N        (N),
      .MSB_FIRST(MSB_FIRST)
   ) u_shift (
      .clk  (clk),
      .rst_n(reset_al_in),
      .en_i (shift_en),
      .clr_i(sync_in),
      .d_i  (d_in),
      .nxt_o(word)
   );

   always_comb begin
      cnt_d = cnt_q;
      if (sync_in) begin
         cnt_d = en_in ? CW'(1) : '0;
      end else if (en_in) begin
         cnt_d = last_bit ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_al_in) begin
      if (!reset_al_in) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

`ifdef SIPO_PARITY_CHECK_EN
   logic par_q, par_d, perr_new, perr_q;

   always_comb begin
      par_d = par_q;
      if (sync_in) begin
         par_d = en_in & d_in;
      end else if (en_in) begin
         par_d = last_bit ? 1'b0 : par_q ^ d_in;
      end
   end

   assign perr_new = par_q ^ d_in;

   always_ff @(posedge clk or negedge reset_al_in) begin
      if (!reset_al_in) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end
`endif

   // Output FSM; the overrun set is written last so it wins over a same-edge clear.
   always_ff @(posedge clk or negedge reset_al_in) begin
      if (!reset_al_in) begin
         state_q <= EMPTY;
         q_q     <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         if (clr_in) begin
            ovr_q <= 1'b0;
         end
         case (state_q)
            EMPTY: begin
               if (done) begin
                  state_q <= FULL;
                  q_q     <= word;
                  valid_q <= 1'b1;
`ifdef SIPO_PARITY_CHECK_EN
                  perr_q  <= perr_new;
`endif
               end
            end
            FULL: begin
               if (done) begin
                  if (ready_in) begin
                     q_q    <= word;
`ifdef SIPO_PARITY_CHECK_EN
                     perr_q <= perr_new;
`endif
                  end else begin
                     ovr_q <= 1'b1;
                  end
               end else if (ready_in) begin
                  state_q <= EMPTY;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= EMPTY;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign q_out       = q_q;
   assign valid_out   = valid_q;
   assign overrun_out = ovr_q;
`ifdef SIPO_PARITY_CHECK_EN
   assign par_err_out = perr_q;
`else
   assign par_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_nbit_rx.sv
// Directed bench for sipo_nbit_rx (N=4); parity frames when SIPO_PARITY_CHECK_EN is defined.
module tb_sipo_nbit_rx;

`ifdef SIPO_PARITY_CHECK_EN
   localparam bit MSB = 1'b1;
`else
   localparam bit MSB = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_al_in = 1'b0;
   logic       en_in = 1'b0, d_in = 1'b0, sync_in = 1'b0, ready_in = 1'b0, clr_in = 1'b0;
   logic [3:0] q_out;
   logic       valid_out, overrun_out, par_err_out;
   int         total = 0;
   int         bad = 0;

   sipo_nbit_rx #(.N(4), .MSB_FIRST(MSB)) dut (
      .clk        (clk),
      .reset_al_in(reset_al_in),
      .en_in      (en_in),
      .d_in       (d_in),
      .sync_in    (sync_in),
      .ready_in   (ready_in),
      .clr_in     (clr_in),
      .q_out      (q_out),
      .valid_out  (valid_out),
      .overrun_out(overrun_out),
      .par_err_out(par_err_out)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step(input logic e, input logic dd, input logic s, input logic r, input logic c);
      en_in = e; d_in = dd; sync_in = s; ready_in = r; clr_in = c;
      @(posedge clk);
      #1;
      en_in = 1'b0; d_in = 1'b0; sync_in = 1'b0; ready_in = 1'b0; clr_in = 1'b0;
   endtask

   // bits[0] is sent first
   task automatic send(input logic [7:0] bits, input int n, input logic r);
      for (int i = 0; i < n; i++) step(1'b1, bits[i], 1'b0, r, 1'b0);
   endtask

   initial begin
      #1;
      check_eq("rst_q", 32'(q_out), 0);
      check_eq("rst_vld", 32'(valid_out), 0);
      check_eq("rst_ovr", 32'(overrun_out), 0);
      check_eq("rst_perr", 32'(par_err_out), 0);
      #12 reset_al_in = 1'b1;

`ifdef SIPO_PARITY_CHECK_EN
      // data 1,0,1,1 (MSB first -> 4'b1011) with good parity 1
      send(8'b0000_1101, 4, 1'b0);
      check_eq("par_no_early_done", 32'(valid_out), 0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("par_q", 32'(q_out), 11);
      check_eq("par_vld", 32'(valid_out), 1);
      check_eq("par_ok", 32'(par_err_out), 0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("par_drain", 32'(valid_out), 0);
      // same data, bad parity 0
      send(8'b0000_1101, 5, 1'b0);
      check_eq("par_q2", 32'(q_out), 11);
      check_eq("par_err", 32'(par_err_out), 1);
      // good frame dropped while FULL: par_err_out unchanged
      send(8'b0001_1101, 5, 1'b0);
      check_eq("par_drop_err", 32'(par_err_out), 1);
      check_eq("par_drop_ovr", 32'(overrun_out), 1);
`else
      // 1,1,0,1 with idle cycles (one carrying d_in=1) mid-word
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("w1_pre_vld", 32'(valid_out), 0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("w1_q", 32'(q_out), 11);
      check_eq("w1_vld", 32'(valid_out), 1);
      check_eq("w1_ovr", 32'(overrun_out), 0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("w1_acc_vld", 32'(valid_out), 0);
      check_eq("w1_acc_q", 32'(q_out), 11);

      // back-to-back words, ready held high
      begin
         logic [7:0] bits = 8'b1101_1011;
         for (int i = 0; i < 8; i++) begin
            step(1'b1, bits[i], 1'b0, 1'b1, 1'b0);
            check_eq("b2b_vld", 32'(valid_out), 32'((i == 3) || (i == 7)));
            if (i == 3) check_eq("b2b_q1", 32'(q_out), 11);
            if (i == 7) check_eq("b2b_q2", 32'(q_out), 13);
         end
      end
      check_eq("b2b_ovr", 32'(overrun_out), 0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // overrun, then set beating a same-edge clear
      send(8'h0B, 4, 1'b0);
      send(8'h0D, 4, 1'b0);
      check_eq("ovr_q", 32'(q_out), 11);
      check_eq("ovr_set", 32'(overrun_out), 1);
      send(8'h0D, 3, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("ovr_set_wins", 32'(overrun_out), 1);
      check_eq("ovr_q_kept", 32'(q_out), 11);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("ovr_clr", 32'(overrun_out), 0);
      check_eq("ovr_clr_vld", 32'(valid_out), 1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("ovr_acc_vld", 32'(valid_out), 0);
      check_eq("ovr_acc_q", 32'(q_out), 11);

      // FULL, ready and completion on the same edge: no bubble, no overrun
      send(8'h0B, 4, 1'b0);
      send(8'h0D, 3, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      check_eq("swap_q", 32'(q_out), 13);
      check_eq("swap_vld", 32'(valid_out), 1);
      check_eq("swap_ovr", 32'(overrun_out), 0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // sync with en_in=1 restarts at bit 0 using the sampled bit
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("sync_pre_vld", 32'(valid_out), 0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("sync_q", 32'(q_out), 13);
      check_eq("sync_vld", 32'(valid_out), 1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // sync with en_in=0 discards a partial word
      send(8'h03, 2, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'h0B, 3, 1'b0);
      check_eq("sync0_pre_vld", 32'(valid_out), 0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("sync0_q", 32'(q_out), 11);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // async reset while FULL with overrun and a partial word
      send(8'h0D, 4, 1'b0);
      send(8'h0B, 4, 1'b0);
      send(8'h03, 2, 1'b0);
      #2 reset_al_in = 1'b0;
      #1;
      check_eq("arst_q", 32'(q_out), 0);
      check_eq("arst_vld", 32'(valid_out), 0);
      check_eq("arst_ovr", 32'(overrun_out), 0);
      #2 reset_al_in = 1'b1;
      send(8'h01, 3, 1'b0);
      check_eq("arst_pre_vld", 32'(valid_out), 0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("arst_q_new", 32'(q_out), 1);
      check_eq("arst_vld_new", 32'(valid_out), 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
